// File: rtl/single_fetch_unit.sv
// single_fetch_unit: instruction-fetch front end. Holds the word-addressed PC,
// issues single-cycle instruction-memory reads and buffers one instruction
// for decode. Handles branch/jump redirects and halt/resume.
// Optional feature macro: FETCH_EXC_EN (adds exc_en input and epc output;
// an exception redirects fetch to EXC_VECTOR and records the faulting PC).
module single_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redir_en,
  input  logic [31:0] redir_pc,
  input  logic        halt_req,
`ifdef FETCH_EXC_EN
  input  logic        exc_en,
  output logic [31:0] epc,
`endif
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              exc_c;
  logic              fetch_req_c;
  logic              fetch_done_c;
  logic              drain_c;

`ifdef FETCH_EXC_EN
  logic [XLEN-1:0]   epc_q, epc_d;
  assign exc_c = exc_en;
`else
  // Exception vector has no use without the exception feature.
  wire unused_exc_vector = ^EXC_VECTOR;
  assign exc_c = 1'b0;
`endif

  // Fetch request: only in RUN, never alongside a redirect/halt, and only
  // when the buffer is empty or being consumed this cycle.
  assign fetch_req_c  = (state_q == RUN) && !exc_c && !redir_en && !halt_req &&
                        (!inst_valid_q || inst_ready);
  assign fetch_done_c = fetch_req_c && im_ack;
  assign drain_c      = inst_valid_q && inst_ready;

  // Next-state and datapath update, priority: exception, redirect, halt, fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
`ifdef FETCH_EXC_EN
    epc_d        = epc_q;
`endif

    if (exc_c) begin
`ifdef FETCH_EXC_EN
      epc_d = inst_valid_q ? inst_pc_q : pc_q;
`endif
      pc_d         = EXC_VECTOR;
      inst_valid_d = 1'b0;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN, HALT: begin
          if (redir_en) begin
            pc_d         = redir_pc;
            inst_valid_d = 1'b0;
            state_d      = RUN;
          end else if ((state_q == RUN) && halt_req) begin
            state_d = HALT;
            if (drain_c) inst_valid_d = 1'b0;
          end else if (fetch_done_c) begin
            inst_d       = im_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + XLEN'(1);
          end else if (drain_c) begin
            inst_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
`ifdef FETCH_EXC_EN
      epc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef FETCH_EXC_EN
      epc_q        <= epc_d;
`endif
    end
  end

  assign im_req     = fetch_req_c;
  assign im_addr    = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = (state_q == HALT);
`ifdef FETCH_EXC_EN
  assign epc        = epc_q;
`endif

endmodule

// File: tb/tb_single_fetch_unit.sv
// Randomized self-checking bench for single_fetch_unit. Memory returns a
// fixed hash of the address, so every buffered instruction must match the
// hash of its own PC. A behavioural model tracks PC, buffer and run mode.
module tb_single_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0001;
  localparam int unsigned N_RAND  = 3000;

  logic        clk;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redir_en;
  logic [31:0] redir_pc;
  logic        halt_req;
  logic        halted;
`ifdef FETCH_EXC_EN
  logic        exc_en;
  logic [31:0] epc;
`endif

  int n_checks;
  int n_fail;

  // Model state: mode 0 = just out of reset, 1 = fetching, 2 = halted.
  logic [31:0] m_pc, m_inst, m_inst_pc, m_epc;
  logic        m_valid;
  int          m_mode;

  single_fetch_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_VEC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .redir_en   (redir_en),
    .redir_pc   (redir_pc),
    .halt_req   (halt_req),
`ifdef FETCH_EXC_EN
    .exc_en     (exc_en),
    .epc        (epc),
`endif
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = '0; m_inst_pc = '0; m_epc = '0;
    m_valid = 1'b0; m_mode = 0;
  endtask

  task automatic check_outputs(input logic exp_req);
    check32("im_req", 32'(im_req), 32'(exp_req));
    check32("im_addr", im_addr, m_pc);
    check32("inst_valid", 32'(inst_valid), 32'(m_valid));
    check32("inst", inst, m_inst);
    check32("inst_pc", inst_pc, m_inst_pc);
    check32("halted", 32'(halted), 32'(m_mode == 2));
`ifdef FETCH_EXC_EN
    check32("epc", epc, m_epc);
`endif
  endtask

  // One clock: called at a falling edge; drives, checks, advances the model,
  // and returns at the next falling edge.
  task automatic cycle(input logic ack, input logic ready, input logic redir,
                       input logic [31:0] rpc, input logic halt, input logic exc);
    logic req;
    logic take_exc;
    take_exc = 1'b0;
`ifdef FETCH_EXC_EN
    take_exc = exc;
    exc_en   = exc;
`endif
    im_ack = ack; inst_ready = ready; redir_en = redir; redir_pc = rpc;
    halt_req = halt; im_data = mem_word(m_pc);
    #1;
    req = (m_mode == 1) && !take_exc && !redir && !halt && (!m_valid || ready);
    check_outputs(req);
    if (take_exc) begin
      m_epc = m_valid ? m_inst_pc : m_pc;
      m_pc = EXC_VEC; m_valid = 1'b0; m_mode = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (redir) begin
      m_pc = rpc; m_valid = 1'b0; m_mode = 1;
    end else if (m_mode == 1 && halt) begin
      m_mode = 2;
      if (m_valid && ready) m_valid = 1'b0;
    end else if (req && ack) begin
      m_inst = mem_word(m_pc); m_inst_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd1;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check32("rst_im_req", 32'(im_req), 32'd0);
    check32("rst_halted", 32'(halted), 32'd0);
    check32("rst_valid", 32'(inst_valid), 32'd0);
    check32("rst_im_addr", im_addr, RST_PC);
    check32("rst_inst", inst, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
  endtask

  initial begin
    logic r_ack, r_rdy, r_redir, r_halt, r_exc;
    logic [31:0] r_pc;
    n_checks = 0; n_fail = 0;
    im_ack = 0; inst_ready = 0; redir_en = 0; redir_pc = '0; halt_req = 0; im_data = '0;
`ifdef FETCH_EXC_EN
    exc_en = 0;
`endif
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Boot cycle, then back-to-back fetch of 0..3.
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check32("seq_addr", im_addr, 32'(i));
      cycle(1, 1, 0, 0, 0, 0);
    end
    check32("seq_inst_pc", inst_pc, 32'd3);

    // Decode stalls for three cycles with the buffer full.
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    check32("stall_inst_pc", inst_pc, 32'd3);
    cycle(1, 1, 0, 0, 0, 0);
    check32("resume_inst_pc", inst_pc, 32'd4);

    // Memory withholds ack at pc=5.
    check32("noack_addr", im_addr, 32'd5);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    check32("noack_drained", 32'(inst_valid), 32'd0);
    cycle(1, 1, 0, 0, 0, 0);
    check32("ack_inst_pc", inst_pc, 32'd5);
    check32("ack_next_addr", im_addr, 32'd6);

    // Redirect coinciding with an ack discards the data.
    cycle(1, 1, 1, 32'h40, 0, 0);
    check32("redir_flush", 32'(inst_valid), 32'd0);
    check32("redir_addr", im_addr, 32'h40);
    cycle(1, 1, 0, 0, 0, 0);
    check32("redir_inst_pc", inst_pc, 32'h40);

    // PC wraps; then halt and resume at 8.
    cycle(1, 1, 1, 32'hFFFF_FFFF, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    check32("wrap_addr", im_addr, 32'd0);
    check32("wrap_inst_pc", inst_pc, 32'hFFFF_FFFF);
    cycle(1, 1, 0, 0, 1, 0);
    check32("halt_halted", 32'(halted), 32'd1);
    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    check32("halt_no_req", 32'(im_req), 32'd0);
    cycle(1, 1, 1, 32'd8, 0, 0);
    check32("resume_halted", 32'(halted), 32'd0);
    check32("resume_addr", im_addr, 32'd8);
    cycle(1, 1, 0, 0, 0, 0);
    check32("resume_inst_pc", inst_pc, 32'd8);

`ifdef FETCH_EXC_EN
    // Exception with pc 7 buffered, then exception racing a redirect.
    cycle(1, 1, 1, 32'd7, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check32("exc_pre_inst_pc", inst_pc, 32'd7);
    cycle(1, 0, 0, 0, 0, 1);
    check32("exc_epc", epc, 32'd7);
    check32("exc_addr", im_addr, EXC_VEC);
    check32("exc_flush", 32'(inst_valid), 32'd0);
    cycle(1, 1, 1, 32'h99, 0, 1);
    check32("exc_wins_addr", im_addr, EXC_VEC);
    check32("exc_wins_epc", epc, EXC_VEC);
`endif

    // Random traffic with one asynchronous reset in the middle.
    for (int unsigned n = 0; n < N_RAND; n++) begin
      if (n == N_RAND / 2) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
      end
      r_ack   = ($urandom_range(3) != 0);
      r_rdy   = ($urandom_range(9) < 7);
      r_redir = ($urandom_range(19) == 0);
      r_halt  = ($urandom_range(29) == 0);
      r_exc   = ($urandom_range(29) == 0);
      r_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
      if (m_mode == 0) begin
        r_redir = 0; r_halt = 0; r_exc = 0;
      end
      cycle(r_ack, r_rdy, r_redir, r_pc, r_halt, r_exc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
